// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-bit multi-cycle multiply/divide unit; divider datapath enabled by `define MULDIV_DIV_EN
package cpu_types_pkg;
    parameter int WORD_W = 32;
endpackage

module muldiv_unit
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] port_A,
    input  logic [WORD_W-1:0] port_B,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic              div_zero,
    output logic              unsupported
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t              r_state;
    logic [5:0]          r_count;
    logic                r_busy, r_done, r_div_zero, r_unsupported, r_neg;
    logic [WORD_W-1:0]   r_hi, r_lo, r_ma;
    logic [2*WORD_W-1:0] r_p;
    logic                w_sa, w_sb, w_skip, w_dz;
    logic [WORD_W-1:0]   w_ma, w_mb, w_hi, w_lo;
    logic [WORD_W:0]     w_msum;
    logic [2*WORD_W-1:0] w_mul_next, w_p_next, w_prod;
    assign w_sa = ~op[0] & port_A[WORD_W-1];
    assign w_sb = ~op[0] & port_B[WORD_W-1];
    assign w_ma = w_sa ? -port_A : port_A;
    assign w_mb = w_sb ? -port_B : port_B;
    assign w_msum = {1'b0, r_p[2*WORD_W-1:WORD_W]} + (r_p[0] ? {1'b0, r_ma} : {(WORD_W+1){1'b0}});
    assign w_mul_next = {w_msum, r_p[WORD_W-1:1]};
    assign w_prod = r_neg ? -w_p_next : w_p_next;
    assign w_lo = w_prod[WORD_W-1:0];
`ifdef MULDIV_DIV_EN
    logic                r_div, r_rneg;
    logic [WORD_W-1:0]   r_mb;
    logic [2*WORD_W:0]   w_shift;
    logic [WORD_W:0]     w_trial;
    logic [2*WORD_W-1:0] w_div_next;
    assign w_shift = {r_p, 1'b0};
    assign w_trial = w_shift[2*WORD_W:WORD_W] - {1'b0, r_mb};
    assign w_div_next = w_trial[WORD_W] ? w_shift[2*WORD_W-1:0] : {w_trial[WORD_W-1:0], w_shift[WORD_W-1:1], 1'b1};
    assign w_p_next = r_div ? w_div_next : w_mul_next;
    assign w_hi = !r_div ? w_prod[2*WORD_W-1:WORD_W] :
                  (r_rneg ? -w_p_next[2*WORD_W-1:WORD_W] : w_p_next[2*WORD_W-1:WORD_W]);
    assign w_skip = 1'b0;
    assign w_dz = r_div & ~|r_mb;
`else
    assign w_p_next = w_mul_next;
    assign w_hi = w_prod[2*WORD_W-1:WORD_W];
    assign w_skip = op[1];
    assign w_dz = 1'b0;
`endif
    // Control FSM: latch operands on accept, one radix-2 step per CALC cycle, publish result on the last step
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_div_zero    <= 1'b0;
            r_unsupported <= 1'b0;
            r_neg         <= 1'b0;
            r_ma          <= '0;
            r_p           <= '0;
`ifdef MULDIV_DIV_EN
            r_div         <= 1'b0;
            r_rneg        <= 1'b0;
            r_mb          <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state != CALC && start) begin
                r_ma    <= w_ma;
                r_p     <= {{WORD_W{1'b0}}, op[1] ? w_ma : w_mb};
                r_neg   <= (w_sa ^ w_sb) & (~op[1] | (|port_B));
                r_count <= 6'd32;
                r_state <= w_skip ? DONE : CALC;
                r_busy  <= ~w_skip;
                r_done  <= w_skip;
`ifdef MULDIV_DIV_EN
                r_div   <= op[1];
                r_mb    <= w_mb;
                r_rneg  <= op[1] & w_sa;
`endif
                if (w_skip) begin
                    r_unsupported <= 1'b1;
                    r_div_zero    <= 1'b0;
                end
            end else if (r_state == CALC) begin
                r_p     <= w_p_next;
                r_count <= r_count - 6'd1;
                if (r_count == 6'd1) begin
                    r_state       <= DONE;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b1;
                    r_hi          <= w_hi;
                    r_lo          <= w_lo;
                    r_div_zero    <= w_dz;
                    r_unsupported <= 1'b0;
                end
            end else begin
                r_state <= IDLE;
            end
        end
    end
    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_zero    = r_div_zero;
    assign unsupported = r_unsupported;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
    logic        CLK = 1'b0, nRST = 1'b0, start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] port_A = '0, port_B = '0;
    logic        busy, done, div_zero, unsupported;
    logic [31:0] hi, lo;
    int          checks = 0, errors = 0;
    logic [63:0] e_hl = '0;

    always #5 CLK = ~CLK;

    muldiv_unit dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op), .port_A(port_A), .port_B(port_B),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero), .unsupported(unsupported)
    );

    // Reference: {hi, lo, div_zero, unsupported} from plain arithmetic on the operands
    function automatic logic [65:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] prev);
        longint x, y;
        logic [63:0] p;
`ifdef MULDIV_DIV_EN
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
`endif
        x = $signed(a);
        y = $signed(b);
        p = prev;
        if (o == MULT) p = x * y;
        else if (o == MULTU) p = {32'b0, a} * {32'b0, b};
`ifdef MULDIV_DIV_EN
        else if (b == 0) p = {a, 32'hFFFFFFFF};
        else if (o == DIVU) p = {a % b, a / b};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
        else p = {32'(sa % sb), 32'(sa / sb)};
        return {p, o[1] && b == 0, 1'b0};
`else
        return {p, 1'b0, o[1]};
`endif
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, scramble inputs after acceptance, observe result, latency and busy cycles
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [65:0] res, output int lat, output int nbusy, output logic held);
        logic [31:0] h0, l0;
        @(negedge CLK);
        h0 = hi; l0 = lo;
        start = 1'b1; op = o; port_A = a; port_B = b;
        @(posedge CLK);
        #1 start = 1'b0; op = 2'($urandom); port_A = $urandom; port_B = $urandom;
        lat = 0; nbusy = 0; held = 1'b1;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge CLK);
            if (done) lat = i;
            else begin
                if (busy) nbusy++;
                if (hi !== h0 || lo !== l0) held = 1'b0;
            end
        end
        res = {hi, lo, div_zero, unsupported};
    endtask

    task automatic test_reset();
        nRST = 1'b0; start = 1'b1; op = MULTU; port_A = 32'h3; port_B = 32'h5;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1; start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if ({busy, done, hi, lo, div_zero, unsupported} !== 68'b0) begin
                errors++;
                $display("FAIL reset_state cyc %0d got busy=%b done=%b hi=%h lo=%h dz=%b un=%b exp all 0",
                         i, busy, done, hi, lo, div_zero, unsupported);
            end
        end
        e_hl = '0;
    endtask

    task automatic test_mult_directed();
        logic [65:0] r; int lat, nb; logic held;
        run_op(MULT, 32'hFFFFFFFE, 32'h3, r, lat, nb, held);
        checks++;
        if (r !== {32'hFFFFFFFF, 32'hFFFFFFFA, 2'b00}) begin
            errors++; $display("FAIL mult_neg got %h exp %h", r, {32'hFFFFFFFF, 32'hFFFFFFFA, 2'b00});
        end
        checks++;
        if ({lat, nb} !== {32'd33, 32'd32}) begin
            errors++; $display("FAIL mult_latency got lat=%0d busy=%0d exp lat=33 busy=32", lat, nb);
        end
        checks++;
        if (held !== 1'b1) begin
            errors++; $display("FAIL mult_hold got held=%b exp 1", held);
        end
        run_op(MULTU, 32'hFFFFFFFE, 32'h3, r, lat, nb, held);
        checks++;
        if (r !== {32'h00000002, 32'hFFFFFFFA, 2'b00}) begin
            errors++; $display("FAIL multu_dir got %h exp %h", r, {32'h00000002, 32'hFFFFFFFA, 2'b00});
        end
        checks++;
        if ({lat, nb, held} !== {32'd33, 32'd32, 1'b1}) begin
            errors++; $display("FAIL multu_timing got lat=%0d busy=%0d held=%b exp 33 32 1", lat, nb, held);
        end
        e_hl = {32'h00000002, 32'hFFFFFFFA};
    endtask

    task automatic test_random_mult();
        logic [65:0] r, e; int lat, nb; logic held;
        logic [1:0] o; logic [31:0] a, b;
        for (int n = 0; n < 16; n++) begin
            o = 2'($urandom_range(0, 1)); a = rnd(); b = rnd();
            e = model(o, a, b, e_hl);
            run_op(o, a, b, r, lat, nb, held);
            checks++;
            if (r !== e || lat != 33 || nb != 32 || !held) begin
                errors++;
                $display("FAIL rand_mult op=%0d a=%h b=%h got %h lat=%0d busy=%0d held=%b exp %h lat=33 busy=32",
                         o, a, b, r, lat, nb, held, e);
            end
            e_hl = e[65:2];
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        logic [65:0] r, e; int lat, nb; logic held;
        logic [1:0] o; logic [31:0] a, b;
        run_op(DIV, 32'hFFFFFFF9, 32'h2, r, lat, nb, held);
        checks++;
        if (r !== {32'hFFFFFFFF, 32'hFFFFFFFD, 2'b00} || lat != 33) begin
            errors++; $display("FAIL div_neg got %h lat=%0d exp %h lat=33", r, lat, {32'hFFFFFFFF, 32'hFFFFFFFD, 2'b00});
        end
        run_op(DIVU, 32'h7, 32'h0, r, lat, nb, held);
        checks++;
        if (r !== {32'h7, 32'hFFFFFFFF, 2'b10} || lat != 33 || nb != 32) begin
            errors++; $display("FAIL divu_zero got %h lat=%0d busy=%0d exp %h 33 32", r, lat, nb, {32'h7, 32'hFFFFFFFF, 2'b10});
        end
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, r, lat, nb, held);
        checks++;
        if (r !== {32'h0, 32'h80000000, 2'b00}) begin
            errors++; $display("FAIL div_ovf got %h exp %h", r, {32'h0, 32'h80000000, 2'b00});
        end
        e_hl = {32'h0, 32'h80000000};
        for (int n = 0; n < 16; n++) begin
            o = 2'($urandom_range(2, 3)); a = rnd(); b = rnd();
            e = model(o, a, b, e_hl);
            run_op(o, a, b, r, lat, nb, held);
            checks++;
            if (r !== e || lat != 33 || nb != 32 || !held) begin
                errors++;
                $display("FAIL rand_div op=%0d a=%h b=%h got %h lat=%0d busy=%0d held=%b exp %h lat=33 busy=32",
                         o, a, b, r, lat, nb, held, e);
            end
            e_hl = e[65:2];
        end
    endtask
`else
    task automatic test_div();
        logic [65:0] r, e; int lat, nb; logic held;
        run_op(MULTU, 32'h8, 32'h5, r, lat, nb, held);
        e_hl = {32'h0, 32'd40};
        e = model(DIV, 32'h8, 32'h2, e_hl);
        run_op(DIV, 32'h8, 32'h2, r, lat, nb, held);
        checks++;
        if (r !== e || r !== {32'h0, 32'd40, 2'b01}) begin
            errors++; $display("FAIL div_unsupported got %h exp %h", r, {32'h0, 32'd40, 2'b01});
        end
        checks++;
        if ({lat, nb} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL div_skip_latency got lat=%0d busy=%0d exp lat=1 busy=0", lat, nb);
        end
        run_op(DIVU, 32'h7, 32'h0, r, lat, nb, held);
        checks++;
        if (r !== {32'h0, 32'd40, 2'b01} || lat != 1) begin
            errors++; $display("FAIL divu_zero_unsupported got %h lat=%0d exp %h lat=1", r, lat, {32'h0, 32'd40, 2'b01});
        end
        run_op(MULT, 32'hFFFFFFFE, 32'h3, r, lat, nb, held);
        checks++;
        if (r !== {32'hFFFFFFFF, 32'hFFFFFFFA, 2'b00} || lat != 33) begin
            errors++; $display("FAIL mult_after_unsupported got %h lat=%0d exp %h lat=33", r, lat, {32'hFFFFFFFF, 32'hFFFFFFFA, 2'b00});
        end
        e_hl = {32'hFFFFFFFF, 32'hFFFFFFFA};
    endtask
`endif

    task automatic test_ignore_start();
        int lat;
        @(negedge CLK);
        start = 1'b1; op = MULTU; port_A = 32'h10000; port_B = 32'h10000;
        @(posedge CLK);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge CLK);
            if (i == 5) begin start = 1'b1; op = MULT; port_A = 32'h1234; port_B = 32'h5678; end
            if (i == 6) begin start = 1'b0; port_A = 32'hDEADBEEF; end
            if (done) lat = i;
        end
        checks++;
        if ({hi, lo} !== 64'h00000001_00000000 || lat != 33) begin
            errors++; $display("FAIL ignore_start got hi=%h lo=%h lat=%0d exp hi=00000001 lo=00000000 lat=33", hi, lo, lat);
        end
        @(negedge CLK);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL ignore_start_idle got busy=%b done=%b exp 0 0", busy, done);
        end
        e_hl = 64'h00000001_00000000;
    endtask

    task automatic test_back_to_back();
        logic [65:0] e1, e2;
        logic [31:0] a1, b1, a2, b2;
        logic ok1, ok2, nobubble;
        a1 = rnd(); b1 = rnd(); a2 = rnd(); b2 = rnd();
        e1 = model(MULTU, a1, b1, e_hl);
        e2 = model(MULT, a2, b2, e1[65:2]);
        @(negedge CLK);
        start = 1'b1; op = MULTU; port_A = a1; port_B = b1;
        @(posedge CLK);
        #1 op = MULT; port_A = a2; port_B = b2;
        ok1 = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            @(negedge CLK);
            if (i == 33) ok1 = done && {hi, lo, div_zero, unsupported} === e1;
        end
        checks++;
        if (!ok1) begin
            errors++; $display("FAIL b2b_first got done=%b %h exp done=1 %h", done, {hi, lo, div_zero, unsupported}, e1);
        end
        @(posedge CLK);
        #1 start = 1'b0;
        ok2 = 1'b0; nobubble = 1'b0;
        for (int j = 1; j <= 33; j++) begin
            @(negedge CLK);
            if (j == 1) nobubble = busy && !done;
            if (j == 33) ok2 = done && {hi, lo, div_zero, unsupported} === e2;
        end
        checks++;
        if (!nobubble) begin
            errors++; $display("FAIL b2b_bubble got no busy in cycle after DONE exp busy=1");
        end
        checks++;
        if (!ok2) begin
            errors++; $display("FAIL b2b_second got done=%b %h exp done=1 %h", done, {hi, lo, div_zero, unsupported}, e2);
        end
        e_hl = e2[65:2];
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        @(negedge CLK);
        start = 1'b1; op = MULTU; port_A = 32'hFFFF0001; port_B = 32'h00030007;
        @(posedge CLK);
        #1 start = 1'b0;
        saw_done = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (i == 10) nRST = 1'b0;
            if (i == 11) nRST = 1'b1;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || {busy, hi, lo, div_zero, unsupported} !== 67'b0) begin
            errors++;
            $display("FAIL reset_abort got done_seen=%b busy=%b hi=%h lo=%h dz=%b un=%b exp 0 0 0 0 0 0",
                     saw_done, busy, hi, lo, div_zero, unsupported);
        end
        nRST = 1'b0; start = 1'b1;
        @(negedge CLK);
        nRST = 1'b1; start = 1'b0;
        @(negedge CLK);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL start_in_reset got busy=%b done=%b exp 0 0", busy, done);
        end
        e_hl = '0;
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_random_mult();
        test_div();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; data width SHALL be WORD_W (32) from cpu_types_pkg.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 nRST  input  1  synchronous active-low reset, sampled on rising CLK.
REQ-004 start  input  1  request strobe from datapath; accepted only when busy=0.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 port_A  input  WORD_W  multiplicand / dividend.
REQ-007 port_B  input  WORD_W  multiplier / divisor.
REQ-008 busy  output  1  operation in progress; new start ignored.
REQ-009 done  output  1  one-cycle pulse: hi/lo hold a new result.
REQ-010 hi  output  WORD_W  product[63:32] or remainder.
REQ-011 lo  output  WORD_W  product[31:0] or quotient.
REQ-012 div_zero  output  1  last completed op was a divide with port_B=0; held until next completion.
REQ-013 unsupported  output  1  last completed op was a divide with division compiled out; held until next completion.

Function
REQ-014 States: IDLE, CALC, DONE; reset state IDLE.
REQ-015 IDLE/DONE with start=1: latch op, port_A, port_B into internal registers, load 6-bit count=32, go to CALC; later input changes SHALL NOT affect the result.
REQ-016 CALC: one radix-2 step per cycle (shift-add multiply, restoring divide); count decrements; at count=1 go to DONE.
REQ-017 Latency: start accepted on edge k -> busy=1 in cycles k+1..k+32 -> done=1, hi/lo/flags updated, busy=0 in cycle k+33.
REQ-018 DONE lasts exactly one cycle, then IDLE unless start=1 (back-to-back accept, no bubble).
REQ-019 start while busy=1 SHALL be ignored with no effect on the running op.
REQ-020 MULT: signed 64-bit product of operands; MULTU: unsigned 64-bit product; sign handled by magnitude compute plus final negate.
REQ-021 DIVU: lo=unsigned quotient, hi=unsigned remainder.
REQ-022 DIV: quotient truncates toward zero; remainder takes sign of dividend.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
REQ-024 Divisor 0 (DIV or DIVU): normal latency, lo=0xFFFFFFFF, hi=dividend, div_zero=1.
REQ-025 hi, lo, div_zero, unsupported SHALL change only in the done cycle and otherwise hold.

Reset
REQ-026 nRST=0 at a rising edge: state IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, unsupported=0, count=0.
REQ-027 Reset during CALC SHALL abort the op with no done pulse and no result update.
REQ-028 start coincident with nRST=0 SHALL be ignored.

Configuration
REQ-029 Macro MULDIV_DIV_EN defined: DIV/DIVU per REQ-021..024; unsupported always 0.
REQ-030 MULDIV_DIV_EN undefined: divider datapath absent; DIV/DIVU accepted, skip CALC, done in cycle k+1 with hi/lo unchanged, unsupported=1, div_zero=0; MULT/MULTU unaffected.

Verification
REQ-031 After reset: busy=0, done=0, hi=lo=0 for 5 cycles with start=0.
REQ-032 MULT A=0xFFFFFFFE(-2), B=3 -> done at k+33, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 DIV A=0xFFFFFFF9(-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7, div_zero=1.
REQ-034 MULTU 0x10000 x 0x10000 started; at k+5 pulse start with other operands and change port_A -> result hi=1, lo=0 at k+33, second start ignored.
REQ-035 Back-to-back: start held 1 through DONE -> second op accepted at k+33, its done at k+66, no bubble.
REQ-036 nRST=0 at k+10 mid-CALC -> no done pulse, hi=lo=0; compile without MULDIV_DIV_EN, DIV 8/2 -> done at k+1, unsupported=1.
